// File: rtl/pmem_burst_scheduler.sv
// pmem_burst_scheduler
//   Arbitrates the single physical-memory port between the instruction-line
//   path and the data-line path. Each grant runs one 4-beat burst. Read beats
//   are assembled into a line. Write lines are serialised one beat at a time.
//   After the last beat, the granted side gets a one-cycle response.
//
//   Ports:
//     clk, rst          clock, asynchronous active-high reset
//     inst_*            instruction line read request / assembled line / resp
//     data_*            data line read or write request / assembled line / resp
//     mem_*             burst address, read/write strobes, beat data, beat resp
//
//   Optional build macro PMEM_SCHED_PERF_EN adds two wait-cycle counters:
//     inst_wait_cnt, data_wait_cnt  saturating counts of cycles in which the
//                                   side requests but does not hold the grant
module pmem_burst_scheduler #(
  parameter int unsigned LINE_W       = 256,
  parameter int unsigned BEAT_W       = 64,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       inst_addr,
  input  logic              inst_read,
  output logic [LINE_W-1:0] inst_rdata,
  output logic              inst_resp,
  input  logic [31:0]       data_addr,
  input  logic              data_read,
  input  logic              data_write,
  input  logic [LINE_W-1:0] data_wdata,
  output logic [LINE_W-1:0] data_rdata,
  output logic              data_resp,
  output logic [31:0]       mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [BEAT_W-1:0] mem_wdata,
  input  logic [BEAT_W-1:0] mem_rdata,
  input  logic              mem_resp
`ifdef PMEM_SCHED_PERF_EN
  ,
  output logic [31:0]       inst_wait_cnt,
  output logic [31:0]       data_wait_cnt
`endif
);

  localparam int unsigned BEATS = LINE_W / BEAT_W;
  localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned SW    = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [31:0] LINE_MASK = ~32'h0000_001F;

  typedef enum logic [2:0] {
    IDLE,
    INST_RD,
    DATA_RD,
    DATA_WR,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     beat_q, beat_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic [31:0]       addr_q, addr_d;
  logic [LINE_W-1:0] wline_q, wline_d;
  logic              side_data_q, side_data_d;
  logic [LINE_W-1:0] inst_line_q, inst_line_d;
  logic [LINE_W-1:0] data_line_q, data_line_d;

  logic last_beat;
  assign last_beat = (beat_q == CW'(BEATS - 1));

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    streak_d    = streak_q;
    addr_d      = addr_q;
    wline_d     = wline_q;
    side_data_d = side_data_q;
    inst_line_d = inst_line_q;
    data_line_d = data_line_q;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_wdata   = '0;
    inst_resp   = 1'b0;
    data_resp   = 1'b0;

    case (state_q)
      IDLE: begin
        // A pending instruction read that has already watched STARVE_LIMIT
        // data grants go by takes priority over any data request.
        if (inst_read && (streak_q == SW'(STARVE_LIMIT))) begin
          state_d     = INST_RD;
          side_data_d = 1'b0;
          addr_d      = inst_addr & LINE_MASK;
          beat_d      = '0;
          streak_d    = '0;
        end else if (data_write || data_read) begin
          state_d     = data_write ? DATA_WR : DATA_RD;
          side_data_d = 1'b1;
          addr_d      = data_addr & LINE_MASK;
          beat_d      = '0;
          if (data_write) begin
            wline_d = data_wdata;
          end
          if (inst_read) begin
            streak_d = streak_q + 1'b1;
          end
        end else if (inst_read) begin
          state_d     = INST_RD;
          side_data_d = 1'b0;
          addr_d      = inst_addr & LINE_MASK;
          beat_d      = '0;
          streak_d    = '0;
        end
      end

      INST_RD, DATA_RD: begin
        mem_read = 1'b1;
        if (mem_resp) begin
          for (int unsigned i = 0; i < BEATS; i++) begin
            if (beat_q == CW'(i)) begin
              if (state_q == DATA_RD) begin
                data_line_d[i*BEAT_W +: BEAT_W] = mem_rdata;
              end else begin
                inst_line_d[i*BEAT_W +: BEAT_W] = mem_rdata;
              end
            end
          end
          beat_d = beat_q + 1'b1;
          if (last_beat) begin
            state_d = DONE;
          end
        end
      end

      DATA_WR: begin
        mem_write = 1'b1;
        for (int unsigned i = 0; i < BEATS; i++) begin
          if (beat_q == CW'(i)) begin
            mem_wdata = wline_q[i*BEAT_W +: BEAT_W];
          end
        end
        if (mem_resp) begin
          beat_d = beat_q + 1'b1;
          if (last_beat) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        inst_resp = ~side_data_q;
        data_resp = side_data_q;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      streak_q    <= '0;
      addr_q      <= '0;
      wline_q     <= '0;
      side_data_q <= 1'b0;
      inst_line_q <= '0;
      data_line_q <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      streak_q    <= streak_d;
      addr_q      <= addr_d;
      wline_q     <= wline_d;
      side_data_q <= side_data_d;
      inst_line_q <= inst_line_d;
      data_line_q <= data_line_d;
    end
  end

  assign mem_addr   = addr_q;
  assign inst_rdata = inst_line_q;
  assign data_rdata = data_line_q;

`ifdef PMEM_SCHED_PERF_EN
  logic [31:0] inst_wait_q, inst_wait_d;
  logic [31:0] data_wait_q, data_wait_d;
  logic        inst_granted, data_granted;

  // The grant is held from the burst state through DONE; IDLE holds no grant.
  assign inst_granted = (state_q == INST_RD) || ((state_q == DONE) && !side_data_q);
  assign data_granted = (state_q == DATA_RD) || (state_q == DATA_WR) ||
                        ((state_q == DONE) && side_data_q);

  always_comb begin
    inst_wait_d = inst_wait_q;
    data_wait_d = data_wait_q;
    if (inst_read && !inst_granted && (inst_wait_q != '1)) begin
      inst_wait_d = inst_wait_q + 32'd1;
    end
    if ((data_read || data_write) && !data_granted && (data_wait_q != '1)) begin
      data_wait_d = data_wait_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_wait_q <= '0;
      data_wait_q <= '0;
    end else begin
      inst_wait_q <= inst_wait_d;
      data_wait_q <= data_wait_d;
    end
  end

  assign inst_wait_cnt = inst_wait_q;
  assign data_wait_cnt = data_wait_q;
`endif

endmodule

// File: tb/tb_pmem_burst_scheduler.sv
// Directed bench for pmem_burst_scheduler: instruction read, paced data
// write, simultaneous requests, starvation rotation, and mid-burst reset.
module tb_pmem_burst_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  inst_addr;
  logic         inst_read;
  logic [255:0] inst_rdata;
  logic         inst_resp;
  logic [31:0]  data_addr;
  logic         data_read;
  logic         data_write;
  logic [255:0] data_wdata;
  logic [255:0] data_rdata;
  logic         data_resp;
  logic [31:0]  mem_addr;
  logic         mem_read;
  logic         mem_write;
  logic [63:0]  mem_wdata;
  logic [63:0]  mem_rdata;
  logic         mem_resp;

  int n_checks = 0;
  int n_fail   = 0;

  pmem_burst_scheduler #(
    .LINE_W      (256),
    .BEAT_W      (64),
    .STARVE_LIMIT(3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .inst_addr (inst_addr),
    .inst_read (inst_read),
    .inst_rdata(inst_rdata),
    .inst_resp (inst_resp),
    .data_addr (data_addr),
    .data_read (data_read),
    .data_write(data_write),
    .data_wdata(data_wdata),
    .data_rdata(data_rdata),
    .data_resp (data_resp),
    .mem_addr  (mem_addr),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_resp  (mem_resp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Acts as the memory for one 4-beat burst: 'gap' idle cycles before each
  // beat response. Reads return 'line' beat by beat; writes check mem_wdata.
  task automatic do_burst(input bit is_write, input int gap, input logic [255:0] line);
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < gap; g++) begin
        mem_resp = 1'b0;
        if (is_write) check("wdata_hold", 256'(mem_wdata), 256'(line[k*64 +: 64]));
        tick();
      end
      mem_resp  = 1'b1;
      mem_rdata = is_write ? 64'h0 : line[k*64 +: 64];
      if (is_write) begin
        check("mem_write_beat", 256'(mem_write), 256'(1));
        check("wdata_beat", 256'(mem_wdata), 256'(line[k*64 +: 64]));
      end else begin
        check("mem_read_beat", 256'(mem_read), 256'(1));
      end
      tick();
    end
    mem_resp  = 1'b0;
    mem_rdata = '0;
  endtask

  logic [255:0] line;

  initial begin
    rst        = 1'b1;
    inst_addr  = '0;
    inst_read  = 1'b0;
    data_addr  = '0;
    data_read  = 1'b0;
    data_write = 1'b0;
    data_wdata = '0;
    mem_rdata  = '0;
    mem_resp   = 1'b0;

    // Reset state
    #1;
    check("rst_mem_read",   256'(mem_read),  256'(0));
    check("rst_mem_write",  256'(mem_write), 256'(0));
    check("rst_inst_resp",  256'(inst_resp), 256'(0));
    check("rst_data_resp",  256'(data_resp), 256'(0));
    check("rst_mem_addr",   256'(mem_addr),  256'(0));
    check("rst_inst_rdata", inst_rdata,      256'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Instruction read, zero-wait memory
    inst_addr = 32'h0000_0064;
    inst_read = 1'b1;
    tick();
    check("i_mem_addr",  256'(mem_addr),  256'(32'h0000_0060));
    check("i_mem_write", 256'(mem_write), 256'(0));
    check("i_resp_early", 256'(inst_resp), 256'(0));
    line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    do_burst(1'b0, 0, line);
    check("i_resp",       256'(inst_resp), 256'(1));
    check("i_data_resp",  256'(data_resp), 256'(0));
    check("i_mem_read_done", 256'(mem_read), 256'(0));
    check("i_rdata",      inst_rdata, line);
    inst_read = 1'b0;
    tick();
    check("i_resp_once",  256'(inst_resp), 256'(0));
    check("i_rdata_hold", inst_rdata, line);

    // Data write, memory responds every other cycle
    data_addr  = 32'h8000_0040;
    data_wdata = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                  64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    line       = data_wdata;
    data_write = 1'b1;
    tick();
    data_wdata = '0;
    data_addr  = 32'hFFFF_FFFF;
    check("w_mem_addr", 256'(mem_addr), 256'(32'h8000_0040));
    check("w_mem_read", 256'(mem_read), 256'(0));
    do_burst(1'b1, 1, line);
    check("w_resp",      256'(data_resp), 256'(1));
    check("w_mem_write_done", 256'(mem_write), 256'(0));
    data_write = 1'b0;
    tick();
    check("w_resp_once",  256'(data_resp), 256'(0));
    check("w_mem_write_after", 256'(mem_write), 256'(0));

    // Simultaneous inst_read and data_read: data first, inst right after
    inst_addr = 32'h1234_5678;
    data_addr = 32'h0000_1010;
    inst_read = 1'b1;
    data_read = 1'b1;
    tick();
    check("s_first_addr", 256'(mem_addr), 256'(32'h0000_1000));
    line = {64'h0D0D_0000_0000_0004, 64'h0D0D_0000_0000_0003,
            64'h0D0D_0000_0000_0002, 64'h0D0D_0000_0000_0001};
    do_burst(1'b0, 0, line);
    check("s_data_resp", 256'(data_resp), 256'(1));
    check("s_inst_resp", 256'(inst_resp), 256'(0));
    check("s_data_rdata", data_rdata, line);
    data_read = 1'b0;
    tick();
    check("s_idle_gap", 256'(mem_read), 256'(0));
    tick();
    check("s_second_addr", 256'(mem_addr), 256'(32'h1234_5660));
    check("s_second_read", 256'(mem_read), 256'(1));
    do_burst(1'b0, 0, {64'h1A1A_0000_0000_0004, 64'h1A1A_0000_0000_0003,
                       64'h1A1A_0000_0000_0002, 64'h1A1A_0000_0000_0001});
    check("s_inst_resp2", 256'(inst_resp), 256'(1));
    check("s_inst_rdata", inst_rdata, {64'h1A1A_0000_0000_0004, 64'h1A1A_0000_0000_0003,
                                       64'h1A1A_0000_0000_0002, 64'h1A1A_0000_0000_0001});
    check("s_data_rdata_hold", data_rdata, line);
    inst_read = 1'b0;
    tick();

    // Starvation: grants go D, D, D, I, then D again once the streak clears
    inst_addr = 32'h0000_2008;
    data_addr = 32'h0000_3010;
    inst_read = 1'b1;
    data_read = 1'b1;
    for (int g = 0; g < 5; g++) begin
      bit exp_data;
      exp_data = (g != 3);
      tick();
      check("strv_grant_addr", 256'(mem_addr),
            exp_data ? 256'(32'h0000_3000) : 256'(32'h0000_2000));
      line = {32'h4, 32'(g), 32'h3, 32'(g), 32'h2, 32'(g), 32'h1, 32'(g)};
      do_burst(1'b0, 0, line);
      if (exp_data) begin
        check("strv_data_resp", 256'(data_resp), 256'(1));
        check("strv_data_rdata", data_rdata, line);
        data_read = 1'b0;
      end else begin
        check("strv_inst_resp", 256'(inst_resp), 256'(1));
        check("strv_inst_rdata", inst_rdata, line);
        inst_read = 1'b0;
      end
      tick();
      if (g < 4) begin
        if (exp_data) data_read = 1'b1;
        else          inst_read = 1'b1;
      end
    end
    inst_read = 1'b0;
    data_read = 1'b0;
    tick();
    check("strv_idle", 256'(mem_read), 256'(0));

    // Reset during beat 2 of a data read
    data_addr = 32'h0000_4020;
    data_read = 1'b1;
    tick();
    mem_resp  = 1'b1;
    mem_rdata = 64'hEEEE_0000_0000_0000;
    tick();
    mem_rdata = 64'hEEEE_0000_0000_0001;
    tick();
    mem_resp  = 1'b0;
    mem_rdata = '0;
    check("r_mid_burst", 256'(mem_read), 256'(1));
    rst = 1'b1;
    #1;
    check("r_async_mem_read",  256'(mem_read),  256'(0));
    check("r_async_mem_write", 256'(mem_write), 256'(0));
    check("r_async_data_resp", 256'(data_resp), 256'(0));
    check("r_async_rdata",     data_rdata,      256'h0);
    data_read = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("r_stay_idle_rd", 256'(mem_read),  256'(0));
    check("r_stay_idle_wr", 256'(mem_write), 256'(0));
    check("r_no_resp",      256'(data_resp), 256'(0));
    data_addr = 32'h0000_5000;
    data_read = 1'b1;
    tick();
    check("r_fresh_addr", 256'(mem_addr), 256'(32'h0000_5000));
    line = {64'h5555_0000_0000_0004, 64'h5555_0000_0000_0003,
            64'h5555_0000_0000_0002, 64'h5555_0000_0000_0001};
    do_burst(1'b0, 0, line);
    check("r_fresh_resp",  256'(data_resp), 256'(1));
    check("r_fresh_rdata", data_rdata, line);
    data_read = 1'b0;
    tick();
    check("r_fresh_resp_once", 256'(data_resp), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
